// File: rtl/alu_sequencer_if.sv
// Request/grant handshake and datapath strobe bundle between the control unit and alu_sequencer.
interface alu_sequencer_if;
    logic        op_req;
    logic [4:0]  opcode;
    logic        pc_req;
    logic        op_ack;
    logic        pc_ack;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        src1_out;
    logic        src2_out;
    logic        y_in;
    logic        z_in;
    logic        zlo_out;
    logic        zhi_out;
    logic        rdst_in;
    logic        lo_in;
    logic        hi_in;
    logic        pc_out;
    logic        pc_in;
    logic [13:0] alu_op;

    modport master (
        output op_req, opcode, pc_req,
        input  op_ack, pc_ack, busy, done, illegal, src1_out, src2_out, y_in, z_in,
               zlo_out, zhi_out, rdst_in, lo_in, hi_in, pc_out, pc_in, alu_op
    );

    modport slave (
        input  op_req, opcode, pc_req,
        output op_ack, pc_ack, busy, done, illegal, src1_out, src2_out, y_in, z_in,
               zlo_out, zhi_out, rdst_in, lo_in, hi_in, pc_out, pc_in, alu_op
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving ALU/register strobes for one ALU op or PC increment at a time.
// Optional MUL/DIV support (LO/HI writeback, longer settle) is enabled by defining ALU_MULDIV_EN.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int MULDIV_SETTLE = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_sequencer_if.slave  bus
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int MAX_SETTLE = (MULDIV_SETTLE > SETTLE_CYCLES) ? MULDIV_SETTLE : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADY, S_EXEC, S_WBLO, S_WBHI, S_PCEX, S_PCWB, S_ILL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic             ack_q, ack_d;

    // One-hot ALU select; a zero result marks the opcode as unsupported.
    function automatic logic [13:0] alu_sel(input logic [4:0] op);
        logic [13:0] sel;
        sel = '0;
        case (op)
            OP_ADD:  sel[0]  = 1'b1;
            OP_SUB:  sel[1]  = 1'b1;
`ifdef ALU_MULDIV_EN
            OP_MUL:  sel[2]  = 1'b1;
            OP_DIV:  sel[3]  = 1'b1;
`endif
            OP_AND:  sel[4]  = 1'b1;
            OP_OR:   sel[5]  = 1'b1;
            OP_SHR:  sel[6]  = 1'b1;
            OP_SHRA: sel[7]  = 1'b1;
            OP_SHL:  sel[8]  = 1'b1;
            OP_ROR:  sel[9]  = 1'b1;
            OP_ROL:  sel[10] = 1'b1;
            OP_NEG:  sel[11] = 1'b1;
            OP_NOT:  sel[12] = 1'b1;
            default: sel     = '0;
        endcase
        return sel;
    endfunction

`ifdef ALU_MULDIV_EN
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction
`endif

    function automatic logic [CNT_W-1:0] settle_of(input logic [4:0] op);
`ifdef ALU_MULDIV_EN
        if (is_muldiv(op))
            return CNT_W'(MULDIV_SETTLE);
`endif
        return CNT_W'(SETTLE_CYCLES);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        ack_d        = 1'b0;
        bus.op_ack   = ack_q;
        bus.pc_ack   = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        bus.src1_out = 1'b0;
        bus.src2_out = 1'b0;
        bus.y_in     = 1'b0;
        bus.z_in     = 1'b0;
        bus.zlo_out  = 1'b0;
        bus.zhi_out  = 1'b0;
        bus.rdst_in  = 1'b0;
        bus.lo_in    = 1'b0;
        bus.hi_in    = 1'b0;
        bus.pc_out   = 1'b0;
        bus.pc_in    = 1'b0;
        bus.alu_op   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.pc_req) begin
                    state_d = S_PCEX;
                end else if (bus.op_req) begin
                    op_d  = bus.opcode;
                    ack_d = 1'b1;
                    if (alu_sel(bus.opcode) == '0) begin
                        state_d = S_ILL;
                    end else if (bus.opcode == OP_NEG || bus.opcode == OP_NOT) begin
                        state_d = S_EXEC;
                        cnt_d   = settle_of(bus.opcode);
                    end else begin
                        state_d = S_LOADY;
                    end
                end
            end
            S_LOADY: begin
                bus.src1_out = 1'b1;
                bus.y_in     = 1'b1;
                state_d      = S_EXEC;
                cnt_d        = settle_of(op_q);
            end
            S_EXEC: begin
                bus.src2_out = 1'b1;
                bus.alu_op   = alu_sel(op_q);
                bus.z_in     = (cnt_q == CNT_W'(1));
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_WBLO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_WBLO: begin
                bus.zlo_out = 1'b1;
`ifdef ALU_MULDIV_EN
                if (is_muldiv(op_q)) begin
                    bus.lo_in = 1'b1;
                    state_d   = S_WBHI;
                end else begin
                    bus.rdst_in = 1'b1;
                    bus.done    = 1'b1;
                    state_d     = S_IDLE;
                end
`else
                bus.rdst_in = 1'b1;
                bus.done    = 1'b1;
                state_d     = S_IDLE;
`endif
            end
`ifdef ALU_MULDIV_EN
            S_WBHI: begin
                bus.zhi_out = 1'b1;
                bus.hi_in   = 1'b1;
                bus.done    = 1'b1;
                state_d     = S_IDLE;
            end
`endif
            S_PCEX: begin
                bus.pc_ack     = 1'b1;
                bus.pc_out     = 1'b1;
                bus.alu_op[13] = 1'b1;
                bus.z_in       = 1'b1;
                state_d        = S_PCWB;
            end
            S_PCWB: begin
                bus.zlo_out = 1'b1;
                bus.pc_in   = 1'b1;
                bus.done    = 1'b1;
                state_d     = S_IDLE;
            end
            S_ILL: begin
                bus.illegal = 1'b1;
                bus.done    = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: per-cycle output traces predicted from the operation rules.
module tb_alu_sequencer;
    localparam int S = 1;
    localparam int M = 4;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef struct packed {
        logic        op_ack;
        logic        pc_ack;
        logic        busy;
        logic        done;
        logic        illegal;
        logic        src1_out;
        logic        src2_out;
        logic        y_in;
        logic        z_in;
        logic        zlo_out;
        logic        zhi_out;
        logic        rdst_in;
        logic        lo_in;
        logic        hi_in;
        logic        pc_out;
        logic        pc_in;
        logic [13:0] alu_op;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_sequencer_if bus ();

    alu_sequencer #(.SETTLE_CYCLES(S), .MULDIV_SETTLE(M)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    out_t obs;
    assign obs = {bus.op_ack, bus.pc_ack, bus.busy, bus.done, bus.illegal, bus.src1_out,
                  bus.src2_out, bus.y_in, bus.z_in, bus.zlo_out, bus.zhi_out, bus.rdst_in,
                  bus.lo_in, bus.hi_in, bus.pc_out, bus.pc_in, bus.alu_op};

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                   5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                                   5'b10010};

    // ALU bit index from the opcode table; -1 means the opcode is illegal.
    function automatic int alu_idx(input logic [4:0] op);
        case (op)
            5'b00011: return 0;
            5'b00100: return 1;
            5'b01111: return MD ? 2 : -1;
            5'b10000: return MD ? 3 : -1;
            5'b01010: return 4;
            5'b01011: return 5;
            5'b00101: return 6;
            5'b00110: return 7;
            5'b00111: return 8;
            5'b01000: return 9;
            5'b01001: return 10;
            5'b10001: return 11;
            5'b10010: return 12;
            default:  return -1;
        endcase
    endfunction

    task automatic check(input string tag, input out_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Expected cycles of one op sequence followed by its mandatory IDLE cycle.
    task automatic push_op(input logic [4:0] op);
        out_t v;
        int   idx;
        int   settle;
        bit   unary;
        bit   md;
        idx = alu_idx(op);
        if (idx < 0) begin
            v = '0; v.op_ack = 1; v.busy = 1; v.illegal = 1; v.done = 1;
            exp_q.push_back(v);
        end else begin
            unary  = (idx == 11) || (idx == 12);
            md     = (idx == 2) || (idx == 3);
            settle = md ? M : S;
            if (!unary) begin
                v = '0; v.op_ack = 1; v.busy = 1; v.src1_out = 1; v.y_in = 1;
                exp_q.push_back(v);
            end
            for (int k = 0; k < settle; k++) begin
                v = '0; v.busy = 1; v.src2_out = 1;
                v.op_ack = unary && (k == 0);
                v.z_in   = (k == settle - 1);
                v.alu_op = 14'(1) << idx;
                exp_q.push_back(v);
            end
            if (md) begin
                v = '0; v.busy = 1; v.zlo_out = 1; v.lo_in = 1;
                exp_q.push_back(v);
                v = '0; v.busy = 1; v.zhi_out = 1; v.hi_in = 1; v.done = 1;
                exp_q.push_back(v);
            end else begin
                v = '0; v.busy = 1; v.zlo_out = 1; v.rdst_in = 1; v.done = 1;
                exp_q.push_back(v);
            end
        end
        exp_q.push_back('0);
    endtask

    task automatic push_pc();
        out_t v;
        v = '0; v.pc_ack = 1; v.busy = 1; v.pc_out = 1; v.z_in = 1; v.alu_op[13] = 1;
        exp_q.push_back(v);
        v = '0; v.busy = 1; v.zlo_out = 1; v.pc_in = 1; v.done = 1;
        exp_q.push_back(v);
        exp_q.push_back('0);
    endtask

    // Checks up to n queued cycles (n<0: all); requests drop once their ack is due.
    task automatic run(input string tag, input int n);
        out_t e;
        int   cnt;
        cnt = 0;
        while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, cnt), e);
            if (e.op_ack) begin
                bus.op_req = 1'b0;
                bus.opcode = 5'($urandom);
            end
            if (e.pc_ack) bus.pc_req = 1'b0;
            cnt++;
        end
    endtask

    task automatic req_op(input logic [4:0] op);
        bus.op_req = 1'b1;
        bus.opcode = op;
        push_op(op);
    endtask

    initial begin
        bus.op_req = 1'b0;
        bus.pc_req = 1'b0;
        bus.opcode = '0;

        #2 check("reset_hold", '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", '0);

        req_op(5'b00011);
        run("add", -1);

        req_op(5'b01111);
        run("mul", -1);

        bus.pc_req = 1'b1;
        push_pc();
        req_op(5'b00100);
        run("pc_prio", -1);

        req_op(5'b11111);
        run("ill", -1);

        req_op(5'b10001);
        run("neg", -1);

        req_op(5'b10010);
        run("not", -1);

        if (MD) begin
            req_op(5'b10000);
            run("div_pre", 3);
        end else begin
            req_op(5'b00111);
            run("shl_pre", 2);
        end
        exp_q.delete();
        rst = 1'b1;
        #1 check("clr_async", '0);
        @(negedge clk);
        check("clr_hold", '0);
        rst = 1'b0;
        @(negedge clk);
        check("clr_release", '0);
        req_op(5'b01010);
        run("after_clr", -1);

        for (int t = 0; t < 60; t++) begin
            int gap;
            int kind;
            logic [4:0] op;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                exp_q.push_back('0);
                run("gap", -1);
            end
            kind = $urandom_range(0, 3);
            op   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 12)];
            if (kind == 0 || kind == 3) begin
                bus.pc_req = 1'b1;
                push_pc();
            end
            if (kind != 0) req_op(op);
            run($sformatf("rand%0d", t), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the shared combinational ALU for one register-register operation at a time. It arbitrates between instruction-operation requests and program-counter increment requests, and drives the Y/Z/HI/LO/PC register strobes and the one-hot ALU operation lines. It sits between the control unit and the datapath bus, replacing hand-sequenced T-step strobes for ALU instructions.

## Interface
- SETTLE_CYCLES, 1, cycles the ALU op is held in EXEC for single-cycle ops (≥1)
- MULDIV_SETTLE, 4, cycles the ALU op is held in EXEC for MUL/DIV (≥1)
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- op_req  in  1  level request for an ALU instruction; held until op_ack
- opcode  in  5  operation code, valid while op_req high
- pc_req  in  1  level request for PC increment; held until pc_ack
- op_ack / pc_ack  out  1  one-cycle grant pulse
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in the final state of a sequence
- illegal  out  1  one-cycle pulse, coincident with done, for an unsupported opcode
- src1_out, src2_out  out  1  drive operand register 1 / 2 onto the bus
- y_in, z_in  out  1  load Y from bus / load 64-bit Z from ALU
- zlo_out, zhi_out  out  1  drive Z[31:0] / Z[63:32] onto the bus
- rdst_in, lo_in, hi_in  out  1  load destination / LO / HI from the bus
- pc_out, pc_in  out  1  drive PC onto the bus / load PC
- alu_op  out  14  one-hot ALU select, [0..13] = ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,IncPC

## Operation
- Opcodes: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. All other opcodes are illegal.
- Moore outputs, registered state. Opcode is captured into an internal register on grant. alu_op is derived from that register, never from the live opcode.
- States: IDLE, LOADY, EXEC, WBLO, WBHI, PCEX, PCWB, ILL.
- IDLE: pc_req has priority over op_req.
  - pc_req → PCEX.
  - op_req with an illegal opcode → ILL.
  - op_req with NEG/NOT → EXEC.
  - op_req with any other opcode → LOADY.
- LOADY: src1_out, y_in → EXEC.
- EXEC: src2_out and the alu_op bit asserted throughout. A down-counter is loaded with SETTLE_CYCLES, or MULDIV_SETTLE for MUL/DIV. z_in is asserted only on the last EXEC cycle, then → WBLO.
- WBLO:
  - Single-cycle ops: zlo_out, rdst_in, done → IDLE.
  - MUL/DIV: zlo_out, lo_in → WBHI.
- WBHI: zhi_out, hi_in, done → IDLE.
- PCEX: pc_out, alu_op[13], z_in → PCWB.
- PCWB: zlo_out, pc_in, done → IDLE.
- ILL: illegal, done; no datapath strobe → IDLE.
- op_ack is high in the first cycle after leaving IDLE on an op grant (LOADY, EXEC or ILL). pc_ack is high in PCEX.
- A requester must deassert its request on the edge after its ack. Requests are not sampled outside IDLE.
- At most one bus driver (src1_out, src2_out, zlo_out, zhi_out, pc_out) is high in any cycle. At most one alu_op bit is high.

## Timing
- Reset: state IDLE, counter 0, captured opcode 0. Every output is 0 while clear is high and on the first cycle after it falls.
- Clear mid-sequence aborts immediately. No done is pulsed and no further strobes are issued.
- Cycles from leaving IDLE to the done cycle inclusive:
  - Binary op: 2+SETTLE_CYCLES.
  - NEG/NOT: 1+SETTLE_CYCLES.
  - MUL/DIV: 3+MULDIV_SETTLE.
  - PC increment: 2.
  - Illegal: 1.
- Back-to-back: after done, the next sequence can begin only after one IDLE cycle.
- pc_req and op_req high together in IDLE: PC is served first. op_req is held and is granted at the next IDLE.

## Configuration
- ALU_MULDIV_EN defined: MUL and DIV are legal and the WBHI path exists.
- ALU_MULDIV_EN undefined:
  - 01111 and 10000 are illegal (ILL path).
  - WBHI and the MULDIV_SETTLE counter load are not compiled.
  - alu_op[2] and alu_op[3], lo_in and hi_in are tied to 0.

## Test plan
- Clear, then op_req with opcode 00011, SETTLE_CYCLES=1 → op_ack and y_in in cycle 1, alu_op=0x0001 with z_in in cycle 2, rdst_in and done in cycle 3, busy low in cycle 4.
- opcode 01111 with MULDIV_SETTLE=4 (macro defined) → alu_op bit 2 held for 4 cycles, z_in on the 4th only, lo_in then hi_in, done in cycle 7.
- op_req and pc_req high together in IDLE → PCEX/PCWB first (alu_op=0x2000, pc_in); op grant follows after one IDLE cycle.
- opcode 11111, and opcode 01111 with the macro undefined → illegal and done pulse in cycle 1, no strobes asserted.
- opcode 10001 (NEG) → no y_in, src2_out with alu_op=0x0800, done in cycle 2.
- clear asserted during EXEC of DIV → all outputs 0 asynchronously, no done; the next request starts cleanly from IDLE.
